// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Types and defaults shared by the data-memory arbiter and its wait counter.
//   arb_state_e : arbiter mode (normal arbitration or host-locked)
//   owner_e     : which requester drives dat_mem this cycle
//   DMEM_AW/DW  : default address / data widths of dat_mem
//   WAIT_W      : width of the host wait counter (holds MAX_WAIT up to 15)
// ---------------------------------------------------------------------------
package dmem_pkg;

    localparam int DMEM_AW = 8;
    localparam int DMEM_DW = 8;
    localparam int WAIT_W  = 4;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        CORE = 2'd1,
        HOST = 2'd2
    } owner_e;

endpackage

// File: rtl/dmem_wait_ctr.sv
// ---------------------------------------------------------------------------
// dmem_wait_ctr
// Counts the cycles a host request has been kept waiting. Saturates at
// MAX_WAIT; at_max tells the arbiter the host must be served this cycle.
// Ports:
//   clk     in  clock
//   reset   in  asynchronous active-low reset
//   inc     in  host waited this cycle (request pending, not granted)
//   clr     in  host granted or request gone; restart the count
//   at_max  out count has reached MAX_WAIT
// ---------------------------------------------------------------------------
module dmem_wait_ctr
    import dmem_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    logic [WAIT_W-1:0] cnt;

    assign at_max = (cnt == WAIT_W'(MAX_WAIT));

    // NOTE: state registers use non-blocking assignments so every flop
    // samples values from before the clock edge, independent of block order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_max) begin
            cnt <= cnt + WAIT_W'(1);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares single-port dat_mem between the core load/store path and a host
// requester. One access per cycle; core has priority, the host is forced in
// after MAX_WAIT lost cycles, and the host may lock the memory for itself.
// Ports:
//   clk, reset                      clock, asynchronous active-low reset
//   core_req/we/addr/wdata          core access request (from Control)
//   core_rdata                      load data, straight from mem_rdata
//   core_stall                      core request not served; hold PC/regs
//   host_req/lock/we/addr/wdata     host request, held until host_gnt
//   host_gnt                        host access performed this cycle
//   host_rdata/host_valid           registered read data + 1-cycle strobe
//   mem_we/addr/wdata, mem_rdata    dat_mem port (combinational read)
// ---------------------------------------------------------------------------
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int AW       = DMEM_AW,
    parameter int DW       = DMEM_DW,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic [DW-1:0] core_rdata,
    output logic          core_stall,
    input  logic          host_req,
    input  logic          host_lock,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic [DW-1:0] host_rdata,
    output logic          host_valid,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    arb_state_e state;
    owner_e     owner;
    logic       at_max;

    // Ownership decision. While reset is low nobody owns the memory, which
    // forces host_gnt, core_stall and mem_we low even mid-access.
    // NOTE: owner gets a default before any branch so this stays purely
    // combinational; a path that skipped the assignment would infer a latch.
    always_comb begin
        owner = NONE;
        if (reset) begin
            if (state == LOCKED) begin
                if (host_req) owner = HOST;
            end else if (host_req && (!core_req || at_max)) begin
                owner = HOST;
            end else if (core_req) begin
                owner = CORE;
            end
        end
    end

    assign host_gnt   = (owner == HOST);
    assign core_stall = reset && core_req && (owner != CORE);
    assign core_rdata = mem_rdata;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = core_addr;
        mem_wdata = core_wdata;
        case (owner)
            HOST: begin
                mem_we    = host_we;
                mem_addr  = host_addr;
                mem_wdata = host_wdata;
            end
            CORE:    mem_we = core_we;
            default: mem_we = 1'b0;
        endcase
    end

    dmem_wait_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_ctr (
        .clk    (clk),
        .reset  (reset),
        .inc    (host_req && !host_gnt),
        .clr    (host_gnt || !host_req),
        .at_max (at_max)
    );

    // Lock is taken on a granted host cycle with host_lock set and held for
    // as long as host_lock stays high, whether or not the host is requesting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ARB;
        end else begin
            case (state)
                ARB:     if (host_gnt && host_lock) state <= LOCKED;
                LOCKED:  if (!host_lock)            state <= ARB;
                default:                            state <= ARB;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            host_valid <= 1'b0;
            host_rdata <= '0;
        end else begin
            host_valid <= host_gnt && !host_we;
            if (host_gnt && !host_we) host_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
// Drives directed and random traffic into dmem_arbiter backed by a simple
// behavioural dat_mem. A reference model predicts each cycle's outputs from
// the arbitration rules; predictions are queued and a separate monitor
// compares them against the DUT just before the next rising edge.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int AW       = 8;
    localparam int DW       = 8;
    localparam int MAX_WAIT = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          core_req = 1'b0, core_we = 1'b0;
    logic [AW-1:0] core_addr = '0;
    logic [DW-1:0] core_wdata = '0;
    logic [DW-1:0] core_rdata;
    logic          core_stall;
    logic          host_req = 1'b0, host_lock = 1'b0, host_we = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic          host_gnt;
    logic [DW-1:0] host_rdata;
    logic          host_valid;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk        (clk),
        .reset      (reset),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_rdata (core_rdata),
        .core_stall (core_stall),
        .host_req   (host_req),
        .host_lock  (host_lock),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_gnt   (host_gnt),
        .host_rdata (host_rdata),
        .host_valid (host_valid),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural dat_mem: combinational read, write on rising edge.
    logic [DW-1:0] mem [256];
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    typedef struct {
        logic          host_gnt;
        logic          core_stall;
        logic          mem_we;
        logic [AW-1:0] mem_addr;
        logic [DW-1:0] mem_wdata;
        logic [DW-1:0] core_rdata;
        logic          host_valid;
        logic [DW-1:0] host_rdata;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0, errors = 0, pushed = 0, popped = 0;
    bit   stop = 0;

    // Staged stimulus, applied to the DUT at the falling edge by step().
    logic          s_rst = 0, s_creq = 0, s_cwe = 0, s_hreq = 0, s_hlock = 0, s_hwe = 0;
    logic [AW-1:0] s_caddr = '0, s_haddr = '0;
    logic [DW-1:0] s_cwdata = '0, s_hwdata = '0;

    // Reference model state: what the memory should hold, whether the host
    // currently owns the memory, how long it has waited, pending read result.
    logic [DW-1:0] ref_mem [256];
    bit            m_locked = 0;
    int            m_wait = 0;
    logic          m_valid = 0;
    logic [DW-1:0] m_hrdata = '0;
    bit            last_gnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    task automatic step();
        exp_t e;
        bit   h_turn, c_turn;
        @(negedge clk);
        reset = s_rst; core_req = s_creq; core_we = s_cwe; core_addr = s_caddr;
        core_wdata = s_cwdata; host_req = s_hreq; host_lock = s_hlock;
        host_we = s_hwe; host_addr = s_haddr; host_wdata = s_hwdata;

        if (!s_rst) begin
            m_locked = 0; m_wait = 0; m_valid = 0; m_hrdata = '0;
        end
        e.host_valid = m_valid;
        e.host_rdata = m_hrdata;

        // Who is served: a locked host always; otherwise the host only when
        // the core is idle or the host has already waited MAX_WAIT cycles.
        h_turn = 0;
        c_turn = 0;
        if (s_rst) begin
            if (m_locked) h_turn = s_hreq;
            else begin
                h_turn = s_hreq && (!s_creq || m_wait >= MAX_WAIT);
                c_turn = s_creq && !h_turn;
            end
        end
        e.host_gnt   = h_turn;
        e.core_stall = s_rst && s_creq && !c_turn;
        e.mem_we     = h_turn ? s_hwe : (c_turn ? s_cwe : 1'b0);
        e.mem_addr   = h_turn ? s_haddr : s_caddr;
        e.mem_wdata  = h_turn ? s_hwdata : s_cwdata;
        e.core_rdata = ref_mem[e.mem_addr];
        exp_q.push_back(e);
        pushed++;

        if (s_rst) begin
            m_valid = h_turn && !s_hwe;
            if (m_valid) m_hrdata = ref_mem[s_haddr];
            if (e.mem_we) ref_mem[e.mem_addr] = e.mem_wdata;
            m_wait   = (s_hreq && !h_turn) ? ((m_wait + 1 > MAX_WAIT) ? MAX_WAIT : m_wait + 1) : 0;
            m_locked = m_locked ? bit'(s_hlock) : (h_turn && s_hlock);
        end
        last_gnt = h_turn;
    endtask

    // Issue one host access and hold it until served (bounded).
    task automatic host_op(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        int n = 0;
        s_hreq = 1; s_hwe = we; s_haddr = addr; s_hwdata = data;
        do begin
            step();
            n++;
        end while (!last_gnt && n < 20);
        check("host_op_bound", 32'(n < 20), 32'd1);
    endtask

    // Monitor: compares one queued prediction per cycle, just before posedge.
    initial begin
        exp_t e;
        while (!stop) begin
            @(negedge clk);
            #4;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                popped++;
                check("host_gnt",   32'(host_gnt),   32'(e.host_gnt));
                check("core_stall", 32'(core_stall), 32'(e.core_stall));
                check("mem_we",     32'(mem_we),     32'(e.mem_we));
                check("mem_addr",   32'(mem_addr),   32'(e.mem_addr));
                check("mem_wdata",  32'(mem_wdata),  32'(e.mem_wdata));
                check("core_rdata", 32'(core_rdata), 32'(e.core_rdata));
                check("host_valid", 32'(host_valid), 32'(e.host_valid));
                check("host_rdata", 32'(host_rdata), 32'(e.host_rdata));
            end
        end
    end

    initial begin
        bit h_busy = 0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end

        // Reset held with both requesters active: nothing may be granted.
        s_rst = 0; s_creq = 1; s_cwe = 1; s_caddr = 8'h10; s_cwdata = 8'hFF;
        s_hreq = 1; s_hwe = 1; s_haddr = 8'h20; s_hwdata = 8'hFF;
        repeat (3) step();
        s_rst = 1; s_creq = 0; s_cwe = 0; s_hreq = 0; s_hwe = 0;
        step();

        // Core only: store 0x5A @0x10, then load it back.
        s_creq = 1; s_cwe = 1; s_caddr = 8'h10; s_cwdata = 8'h5A; step();
        s_cwe = 0; s_cwdata = 8'h00; step();
        s_creq = 0; step();

        // Host only: write 0x33 @0x20, read it back.
        host_op(1'b1, 8'h20, 8'h33);
        host_op(1'b0, 8'h20, 8'h00);
        s_hreq = 0; step(); step();

        // Contention: both request continuously; host forced in every 5th cycle.
        s_creq = 1; s_cwe = 0; s_caddr = 8'h10;
        s_hreq = 1; s_hwe = 0; s_haddr = 8'h20;
        repeat (15) step();

        // Lock: eight host writes 0x00..0x07 @0x40.. with the core requesting.
        s_hlock = 1;
        for (int i = 0; i < 8; i++) host_op(1'b1, 8'h40 + 8'(i), 8'(i));
        s_hlock = 0; s_hreq = 0; s_hwe = 0;
        repeat (3) step();
        s_creq = 0;

        // Reset pulse in the cycle after a host read grant: no host_valid.
        host_op(1'b0, 8'h41, 8'h00);
        s_hreq = 0; s_rst = 0; step();
        // Host write granted-looking cycle while reset low: must not land.
        s_hreq = 1; s_hwe = 1; s_haddr = 8'h41; s_hwdata = 8'hEE; step();
        s_hreq = 0; s_hwe = 0; s_rst = 1; step();
        s_creq = 1; s_caddr = 8'h41; step();

        // Host withdraws after two lost cycles, then retries from zero wait.
        s_hreq = 1; s_haddr = 8'h20; step(); step();
        s_hreq = 0; step();
        host_op(1'b0, 8'h20, 8'h00);
        s_hreq = 0; s_creq = 0; step();

        // Randomised traffic.
        for (int n = 0; n < 800; n++) begin
            if (!h_busy && $urandom_range(0, 2) == 0) begin
                h_busy   = 1;
                s_hwe    = 1'($urandom);
                s_haddr  = 8'($urandom_range(0, 15));
                s_hwdata = 8'($urandom);
            end else if (h_busy && $urandom_range(0, 15) == 0) begin
                h_busy = 0;
            end
            s_hreq   = h_busy;
            s_hlock  = ($urandom_range(0, 4) == 0);
            s_creq   = 1'($urandom);
            s_cwe    = 1'($urandom);
            s_caddr  = 8'($urandom_range(0, 15));
            s_cwdata = 8'($urandom);
            s_rst    = ($urandom_range(0, 99) != 0);
            step();
            if (last_gnt) h_busy = 0;
        end

        s_rst = 1; s_creq = 0; s_hreq = 0; s_hlock = 0;
        repeat (3) step();
        @(negedge clk);
        #6;
        stop = 1;
        @(negedge clk);
        #6;
        check("scoreboard_drained", 32'(popped), 32'(pushed));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
